md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide responder that owns the HI/LO register pair for the MIPS CPU.
- The execute stage issues mult/multu/div/divu/mthi/mtlo via a start/busy/done handshake. It reads HI/LO for mfhi/mflo from this block's outputs.
- Replaces combinational HI/LO arithmetic with an iterative 32-step datapath.

Parameters:
- XLEN, 32, operand and HI/LO width
- ITER, 32, iteration cycles per mult/div; must equal XLEN

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue request; sampled only while busy=0
- funct  in  6  instruction[5:0]: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo
- rs_data  in  32  operand A (dividend / multiplicand / mthi-mtlo source)
- rt_data  in  32  operand B (divisor / multiplier)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: HI/LO updated by a mult/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset, synchronous and active-high:
  - Outputs: busy=0, done=0, hi=0, lo=0.
  - Internal state: state=IDLE, iteration counter=0.
  - A reset mid-operation aborts the operation; no partial result reaches HI/LO.
- States: IDLE, CALC, FIX.
- IDLE, start=1, funct=mthi/mtlo:
  - hi (or lo) <= rs_data at that edge.
  - State stays IDLE; busy and done stay 0.
- IDLE, start=1, funct=mult/multu/div/divu:
  - Latch operands, op and signedness at edge E0.
  - For signed ops, latch absolute values plus result-sign flags.
  - Counter=0, state->CALC, busy=1 from after E0.
- IDLE, start=1, any other funct: ignored.
- CALC: one step per edge E1..E32; counter increments; leave to FIX when counter reaches ITER-1.
  - mult: shift-add on a 64-bit product register.
  - div: restoring division, one quotient bit per step (64-bit remainder/quotient register).
- FIX (edge E33):
  - Apply sign correction and write HI/LO.
  - done=1 for exactly the cycle after E33; busy=0 from that cycle; state->IDLE.
- Latency: a request accepted at E0 gives results visible on hi/lo, with done=1, after E33.
- A new start is accepted in the same cycle done=1 (back-to-back issue allowed).
- start while busy=1 is ignored for every funct, including mthi/mtlo. The issuer holds/stalls until busy=0.
- hi/lo hold their old values throughout CALC; mfhi during busy returns pre-op values. The issuer must stall mfhi/mflo while busy.
- mult: signed 32x32 -> 64; {hi,lo} = product. multu: unsigned.
- div (signed):
  - lo = quotient truncated toward zero.
  - hi = remainder with the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero, both signed and unsigned: lo=32'hFFFFFFFF, hi=rs_data. Full 33-cycle latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0.
- Operand ports are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset; mthi 0x12345678 then mtlo 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 the next cycle; busy and done never assert.
- mult rs=0xFFFFFFFF (-1), rt=0x00000002 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses 1 cycle. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- Boundary cases:
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu 5/0 -> lo=0xFFFFFFFF, hi=5.
- Issue mult; pulse start with mtlo at cycle 10 (ignored; lo unchanged until FIX). Issue a second mult in the done cycle; it is accepted and completes 33 edges later.
- Assert reset at cycle 15 of a div -> next cycle busy=0, hi=lo=0, no done pulse. A following divu 9/3 completes correctly: lo=3, hi=0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the MIPS HI/LO pair.
//   A request is accepted in IDLE. CALC then runs one shift-add or restoring
//   division step per clock. FIX applies the sign correction and writes HI/LO.
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high
//   start    - issue request, sampled only while busy=0
//   funct    - instruction[5:0]: mult/multu/div/divu/mthi/mtlo
//   rs_data  - operand A (dividend / multiplicand / mthi-mtlo source)
//   rt_data  - operand B (divisor / multiplier)
//   busy     - iterative operation in progress
//   done     - one-cycle pulse after HI/LO are written by a mult/div
//   hi, lo   - HI/LO registers
module md_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;     // product, or {remainder, quotient}
   logic [XLEN-1:0]     b_q, b_d;         // |multiplicand| or |divisor|
   logic [XLEN-1:0]     rs_q, rs_d;       // raw dividend for divide-by-zero HI
   logic                div_q, div_d;
   logic                negq_q, negq_d;   // negate product / quotient
   logic                negr_q, negr_d;   // negate remainder
   logic [XLEN-1:0]     hi_q, hi_d;
   logic [XLEN-1:0]     lo_q, lo_d;
   logic                done_q, done_d;

   logic                sgn;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic [2*XLEN:0]     sh;
   logic [XLEN:0]       sum;
   logic [2*XLEN-1:0]   prod;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      rs_d    = rs_q;
      div_d   = div_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      sgn     = ~funct[0];
      abs_a   = rs_data;
      abs_b   = rt_data;
      sh      = '0;
      sum     = '0;
      prod    = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               unique case (funct)
                  F_MTHI: hi_d = rs_data;
                  F_MTLO: lo_d = rs_data;
                  F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                     // Signed ops iterate on magnitudes; signs are restored in FIX.
                     if (sgn && rs_data[XLEN-1]) abs_a = -rs_data;
                     if (sgn && rt_data[XLEN-1]) abs_b = -rt_data;
                     acc_d   = {{XLEN{1'b0}}, abs_a};
                     b_d     = abs_b;
                     rs_d    = rs_data;
                     div_d   = funct[1];
                     negq_d  = sgn & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                     negr_d  = sgn & rs_data[XLEN-1];
                     cnt_d   = '0;
                     state_d = CALC;
                  end
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (div_q) begin
               // Restoring step: shift in, trial-subtract, set quotient bit.
               sh = {acc_q, 1'b0};
               if (sh[2*XLEN:XLEN] >= {1'b0, b_q}) begin
                  sh[2*XLEN:XLEN] = sh[2*XLEN:XLEN] - {1'b0, b_q};
                  sh[0] = 1'b1;
               end
               acc_d = sh[2*XLEN-1:0];
            end else begin
               // Shift-add: multiplier bits consumed from the low half.
               sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
               acc_d = {sum, acc_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = FIX;
         end
         FIX: begin
            if (div_q) begin
               if (b_q == '0) begin
                  lo_d = '1;
                  hi_d = rs_q;
               end else begin
                  lo_d = negq_q ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
                  hi_d = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
               end
            end else begin
               prod = negq_q ? -acc_q : acc_q;
               hi_d = prod[2*XLEN-1:XLEN];
               lo_d = prod[XLEN-1:0];
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         rs_q    <= '0;
         div_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         rs_q    <= rs_d;
         div_q   <= div_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, table-driven check of md_unit plus hand-written
// sequences for ignored starts, back-to-back issue and mid-operation reset.
module tb_md_unit;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   md_unit #(.XLEN(32), .ITER(32)) dut (
      .clock(clock), .reset(reset), .start(start), .funct(funct),
      .rs_data(rs_data), .rt_data(rt_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at #1 after a rising edge; the next rising edge is E0.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; funct = f; rs_data = a; rt_data = b;
      @(posedge clock); #1;
      start = 1'b0; funct = '0;
      rs_data = ~a; rt_data = b ^ 32'h5A5A_5A5A;   // must not affect the result
   endtask

   // Counts edges after E0 until done; checks busy and HI/LO hold mid-operation.
   task automatic wait_done(input string tag, input logic [31:0] phi, input logic [31:0] plo);
      int lat;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (i == 5) begin
            check({tag, " busy mid-op"}, {31'b0, busy}, 32'd1);
            check({tag, " hi held"}, hi, phi);
            check({tag, " lo held"}, lo, plo);
         end
         if (done) begin lat = i; break; end
      end
      check({tag, " latency"}, lat, 32'd33);
      check({tag, " busy at done"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] phi, plo;
      int ndone;

      vecs[0]  = '{F_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[6]  = '{F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{F_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[10] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[11] = '{F_MULT,  32'h00012345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFEDCBB};

      repeat (3) @(posedge clock);
      #1;
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      reset = 1'b0;

      // mthi / mtlo write in one edge, never raise busy/done
      issue(F_MTHI, 32'h12345678, 32'h0);
      check("mthi hi", hi, 32'h12345678);
      check("mthi busy", {31'b0, busy}, 32'd0);
      check("mthi done", {31'b0, done}, 32'd0);
      issue(F_MTLO, 32'h9ABCDEF0, 32'h0);
      check("mtlo lo", lo, 32'h9ABCDEF0);
      check("mtlo hi kept", hi, 32'h12345678);
      check("mtlo busy", {31'b0, busy}, 32'd0);

      // unknown funct is ignored
      issue(6'h20, 32'hAAAA5555, 32'h1);
      check("bad funct busy", {31'b0, busy}, 32'd0);
      check("bad funct hi", hi, 32'h12345678);
      check("bad funct lo", lo, 32'h9ABCDEF0);

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         phi = hi; plo = lo;
         issue(vecs[k].f, vecs[k].a, vecs[k].b);
         wait_done(tag, phi, plo);
         check({tag, " hi"}, hi, vecs[k].ehi);
         check({tag, " lo"}, lo, vecs[k].elo);
         @(posedge clock); #1;
         check({tag, " done pulse width"}, {31'b0, done}, 32'd0);
      end

      // mtlo during busy is ignored; second mult issued in the done cycle
      phi = hi; plo = lo;
      issue(F_MULT, 32'd3, 32'd5);
      repeat (9) @(posedge clock);
      #1;
      start = 1'b1; funct = F_MTLO; rs_data = 32'hDEADBEEF;
      @(posedge clock); #1;
      start = 1'b0; funct = '0;
      check("mtlo while busy lo", lo, plo);
      ndone = 0;
      for (int i = 0; i < 40 && ndone == 0; i++) begin
         @(posedge clock); #1;
         if (done) ndone = 1;
      end
      check("b2b first done", ndone, 32'd1);
      check("b2b first hi", hi, 32'd0);
      check("b2b first lo", lo, 32'd15);
      issue(F_MULT, 32'd6, 32'hFFFFFFF9);
      check("b2b accepted busy", {31'b0, busy}, 32'd1);
      wait_done("b2b second", 32'd0, 32'd15);
      check("b2b second hi", hi, 32'hFFFFFFFF);
      check("b2b second lo", lo, 32'hFFFFFFD6);

      // reset in the middle of a div aborts it
      issue(F_DIV, 32'd100, 32'd7);
      repeat (14) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort done", {31'b0, done}, 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done || busy) ndone++;
      end
      check("abort no done/busy", ndone, 32'd0);
      issue(F_DIVU, 32'd9, 32'd3);
      wait_done("post-reset divu", 32'd0, 32'd0);
      check("post-reset divu hi", hi, 32'd0);
      check("post-reset divu lo", lo, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
